// File: rtl/alu_pkg.sv
// Shared definitions for the two-word ALU sequencer: command codes, FSM states,
// result flags and the low-to-high command mapping.
package alu_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // The high word always chains the carry, so plain ADD/SUB become ADC/SBC.
  function automatic logic [3:0] hi_cmd(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD, CMD_ADC: hi_cmd = CMD_ADC;
      CMD_SUB, CMD_SBC: hi_cmd = CMD_SBC;
      default:          hi_cmd = cmd;
    endcase
  endfunction

  function automatic logic is_arith(input logic [3:0] cmd);
    is_arith = (cmd == CMD_ADD) || (cmd == CMD_ADC) ||
               (cmd == CMD_SUB) || (cmd == CMD_SBC);
  endfunction

  function automatic logic is_known(input logic [3:0] cmd);
    case (cmd)
      CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
      CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR: is_known = 1'b1;
      default:                            is_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wide_cmd_map.sv
// Combinational command/carry selection for the ALU port in each sequencer state.
module wide_cmd_map
  import alu_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] cmd,
  input  logic       c_lo,
  input  logic       req_cin,
  output logic [3:0] alu_cmd,
  output logic       alu_cin
);

  logic [3:0] hcmd;
  assign hcmd = hi_cmd(cmd);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    alu_cmd = CMD_NOP;
    alu_cin = 1'b0;
    unique case (state)
      ST_LO: begin
        alu_cmd = cmd;
        alu_cin = req_cin;
      end
      ST_HI: begin
        alu_cmd = hcmd;
        // Subtract carry out of the ALU is a borrow, so it is inverted before chaining.
        if (hcmd == CMD_ADC)      alu_cin = c_lo;
        else if (hcmd == CMD_SBC) alu_cin = ~c_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_wide_seq.sv
// Drives a WORD_W-bit ALU twice (low word, then high word with chained carry) to
// produce a 2*WORD_W result with NZCV. Optional feature macro: ALU_SEQ_SINGLE_EN.
module alu_wide_seq
  import alu_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_cmd,
  input  logic [2*WORD_W-1:0] req_a,
  input  logic [2*WORD_W-1:0] req_b,
  input  logic                req_cin,
`ifdef ALU_SEQ_SINGLE_EN
  input  logic                req_single,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*WORD_W-1:0] rsp_data,
  output logic                rsp_n,
  output logic                rsp_z,
  output logic                rsp_c,
  output logic                rsp_v,
  output logic [WORD_W-1:0]   alu_in1,
  output logic [WORD_W-1:0]   alu_in2,
  output logic                alu_cin,
  output logic [3:0]          alu_cmd,
  input  logic [WORD_W-1:0]   alu_out,
  input  logic                alu_cout,
  input  logic                alu_v,
  input  logic                alu_z
);

  state_e              state_q, state_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [2*WORD_W-1:0] a_q, a_d, b_q, b_d;
  logic                cin_q, cin_d;
  logic [WORD_W-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic                c_lo_q, c_lo_d, z_lo_q, z_lo_d;
  flags_t              flags_q, flags_d;
  logic                accept;

`ifdef ALU_SEQ_SINGLE_EN
  logic single_q, single_d;
`else
  logic single_q;
  assign single_q = 1'b0;
`endif

  // Unknown commands are masked to a zero word; only arithmetic reports C and V.
  logic [WORD_W-1:0] word_res;
  logic              word_z, word_c, word_v;
  assign word_res = is_known(cmd_q) ? alu_out : '0;
  assign word_z   = is_known(cmd_q) ? alu_z : 1'b1;
  assign word_c   = is_arith(cmd_q) & alu_cout;
  assign word_v   = is_arith(cmd_q) & alu_v;

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_LO;
      ST_LO:   state_d = single_q ? ST_DONE : ST_HI;
      ST_HI:   state_d = ST_DONE;
      ST_DONE: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE) && !rst;
    rsp_valid = (state_q == ST_DONE);
    alu_in1   = '0;
    alu_in2   = '0;
    if (state_q == ST_LO) begin
      alu_in1 = a_q[WORD_W-1:0];
      alu_in2 = b_q[WORD_W-1:0];
    end else if (state_q == ST_HI) begin
      alu_in1 = a_q[2*WORD_W-1:WORD_W];
      alu_in2 = b_q[2*WORD_W-1:WORD_W];
    end
  end

  wide_cmd_map u_cmd_map (
    .state   (state_q),
    .cmd     (cmd_q),
    .c_lo    (c_lo_q),
    .req_cin (cin_q),
    .alu_cmd (alu_cmd),
    .alu_cin (alu_cin)
  );

  always_comb begin
    cmd_d    = cmd_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    c_lo_d   = c_lo_q;
    z_lo_d   = z_lo_q;
    flags_d  = flags_q;
`ifdef ALU_SEQ_SINGLE_EN
    single_d = single_q;
    if (accept) single_d = req_single;
`endif
    if (accept) begin
      cmd_d = req_cmd;
      a_d   = req_a;
      b_d   = req_b;
      cin_d = req_cin;
    end
    if (state_q == ST_LO) begin
      res_lo_d = word_res;
      c_lo_d   = alu_cout;
      z_lo_d   = word_z;
      if (single_q) begin
        res_hi_d = '0;
        flags_d  = '{n: word_res[WORD_W-1], z: word_z, c: word_c, v: word_v};
      end
    end else if (state_q == ST_HI) begin
      res_hi_d = word_res;
      flags_d  = '{n: word_res[WORD_W-1], z: z_lo_q & word_z, c: word_c, v: word_v};
    end
  end

  // NOTE: datapath registers are reset as well so the result and flag outputs read zero after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q    <= CMD_NOP;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      c_lo_q   <= 1'b0;
      z_lo_q   <= 1'b0;
      flags_q  <= '0;
`ifdef ALU_SEQ_SINGLE_EN
      single_q <= 1'b0;
`endif
    end else begin
      cmd_q    <= cmd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      c_lo_q   <= c_lo_d;
      z_lo_q   <= z_lo_d;
      flags_q  <= flags_d;
`ifdef ALU_SEQ_SINGLE_EN
      single_q <= single_d;
`endif
    end
  end

  assign rsp_data = {res_hi_q, res_lo_q};
  assign rsp_n    = flags_q.n;
  assign rsp_z    = flags_q.z;
  assign rsp_c    = flags_q.c;
  assign rsp_v    = flags_q.v;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq with a behavioural 32-bit ALU on the alu_* port.
module tb_alu_wide_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid, req_ready, req_cin, rsp_valid, rsp_ready;
  logic [3:0]     req_cmd, alu_cmd;
  logic [2*W-1:0] req_a, req_b, rsp_data;
  logic           rsp_n, rsp_z, rsp_c, rsp_v;
  logic [W-1:0]   alu_in1, alu_in2, alu_out;
  logic           alu_cin, alu_cout, alu_v, alu_z;
  logic [32:0]    alu_sum;

  int errors = 0;
  int checks = 0;
  int lat;
  logic [3:0] hi_cmd_seen;
  logic       hi_cin_seen;

  always #5 clk = ~clk;

  alu_wide_seq #(.WORD_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ALU_SEQ_SINGLE_EN
    .req_single(1'b0),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_n     (rsp_n),
    .rsp_z     (rsp_z),
    .rsp_c     (rsp_c),
    .rsp_v     (rsp_v),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_cin   (alu_cin),
    .alu_cmd   (alu_cmd),
    .alu_out   (alu_out),
    .alu_cout  (alu_cout),
    .alu_v     (alu_v),
    .alu_z     (alu_z)
  );

  // Reference ALU: subtract reports borrow on cout; logical ops deliberately raise
  // cout/v and unknown codes return junk so the sequencer's masking is exercised.
  always_comb begin
    alu_sum  = '0;
    alu_out  = '0;
    alu_cout = 1'b0;
    alu_v    = 1'b0;
    case (alu_cmd)
      4'b0001: alu_out = alu_in2;
      4'b1001: alu_out = ~alu_in2;
      4'b0010, 4'b0011: begin
        alu_sum  = {1'b0, alu_in1} + {1'b0, alu_in2} + ((alu_cmd == 4'b0011) ? 33'(alu_cin) : 33'd0);
        alu_out  = alu_sum[31:0];
        alu_cout = alu_sum[32];
        alu_v    = (alu_in1[31] == alu_in2[31]) && (alu_out[31] != alu_in1[31]);
      end
      4'b0100, 4'b0101: begin
        alu_sum  = {1'b0, alu_in1} + {1'b0, ~alu_in2} + ((alu_cmd == 4'b0101) ? 33'(alu_cin) : 33'd1);
        alu_out  = alu_sum[31:0];
        alu_cout = ~alu_sum[32];
        alu_v    = (alu_in1[31] != alu_in2[31]) && (alu_out[31] != alu_in1[31]);
      end
      4'b0110: begin alu_out = alu_in1 & alu_in2; alu_cout = 1'b1; alu_v = 1'b1; end
      4'b0111: begin alu_out = alu_in1 | alu_in2; alu_cout = 1'b1; alu_v = 1'b1; end
      4'b1000: begin alu_out = alu_in1 ^ alu_in2; alu_cout = 1'b1; alu_v = 1'b1; end
      default: begin alu_out = 32'hDEAD_BEEF; alu_cout = 1'b1; alu_v = 1'b1; end
    endcase
    alu_z = (alu_out == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, scrambles req_* after the accept edge, and returns the
  // number of edges (accept edge counted as 1) until rsp_valid, or -1 on timeout.
  task automatic run_op(input logic [3:0] cmd, input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                        input logic cin, output int n);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b; req_cin = cin;
    tick();
    req_valid = 1'b0; req_cmd = 4'b0001; req_a = ~a; req_b = ~b; req_cin = ~cin;
    n = 1;
    while (!rsp_valid && n < 20) begin
      if (n == 2) begin hi_cmd_seen = alu_cmd; hi_cin_seen = alu_cin; end
      tick();
      n++;
    end
    if (!rsp_valid) n = -1;
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 1'b0; req_cmd = '0; req_a = '0; req_b = '0; req_cin = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 64'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    checks++; if ({rsp_n, rsp_z, rsp_c, rsp_v} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {rsp_n, rsp_z, rsp_c, rsp_v}); end
    checks++; if ({alu_in1, alu_in2, alu_cmd, alu_cin} !== '0) begin errors++; $display("FAIL reset_alu_port got %h/%h/%b/%b exp all 0", alu_in1, alu_in2, alu_cmd, alu_cin); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_add_carry();
    run_op(4'b0010, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++; if (rsp_data !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL add_carry_data got %h exp 0000000100000000", rsp_data); end
    checks++; if ({rsp_n, rsp_z, rsp_c, rsp_v} !== 4'b0000) begin errors++; $display("FAIL add_carry_flags got %b exp 0000", {rsp_n, rsp_z, rsp_c, rsp_v}); end
    checks++; if (hi_cmd_seen !== 4'b0011) begin errors++; $display("FAIL add_hi_cmd got %b exp 0011", hi_cmd_seen); end
    checks++; if (hi_cin_seen !== 1'b1) begin errors++; $display("FAIL add_hi_cin got %b exp 1", hi_cin_seen); end
    release_rsp();
  endtask

  task automatic test_sub_borrow();
    run_op(4'b0100, 64'h0000_0001_0000_0000, 64'h1, 1'b0, lat);
    checks++; if (rsp_data !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL sub_borrow_data got %h exp 00000000ffffffff", rsp_data); end
    checks++; if ({rsp_n, rsp_z, rsp_c, rsp_v} !== 4'b0000) begin errors++; $display("FAIL sub_borrow_flags got %b exp 0000", {rsp_n, rsp_z, rsp_c, rsp_v}); end
    checks++; if (hi_cmd_seen !== 4'b0101) begin errors++; $display("FAIL sub_hi_cmd got %b exp 0101", hi_cmd_seen); end
    checks++; if (hi_cin_seen !== 1'b0) begin errors++; $display("FAIL sub_hi_cin got %b exp 0", hi_cin_seen); end
    release_rsp();
  endtask

  task automatic test_add_overflow();
    run_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++; if (rsp_data !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_ovf_data got %h exp 8000000000000000", rsp_data); end
    checks++; if ({rsp_n, rsp_z, rsp_c, rsp_v} !== 4'b1001) begin errors++; $display("FAIL add_ovf_flags got %b exp 1001", {rsp_n, rsp_z, rsp_c, rsp_v}); end
    release_rsp();
  endtask

  task automatic test_and_latency();
    run_op(4'b0110, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL and_latency got %0d exp 3", lat); end
    checks++; if (rsp_data !== 64'h0) begin errors++; $display("FAIL and_data got %h exp 0", rsp_data); end
    checks++; if ({rsp_n, rsp_z, rsp_c, rsp_v} !== 4'b0100) begin errors++; $display("FAIL and_flags got %b exp 0100", {rsp_n, rsp_z, rsp_c, rsp_v}); end
    release_rsp();
  endtask

  task automatic test_carry_in();
    run_op(4'b0011, 64'h1, 64'h1, 1'b1, lat);
    checks++; if (rsp_data !== 64'h3) begin errors++; $display("FAIL adc_cin_data got %h exp 3", rsp_data); end
    release_rsp();
    run_op(4'b0101, 64'h5, 64'h3, 1'b0, lat);
    checks++; if (rsp_data !== 64'h1) begin errors++; $display("FAIL sbc_cin_data got %h exp 1", rsp_data); end
    checks++; if ({rsp_n, rsp_z, rsp_c, rsp_v} !== 4'b0000) begin errors++; $display("FAIL sbc_cin_flags got %b exp 0000", {rsp_n, rsp_z, rsp_c, rsp_v}); end
    release_rsp();
  endtask

  task automatic test_undefined();
    run_op(4'b1111, 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b1, lat);
    checks++; if (rsp_data !== 64'h0) begin errors++; $display("FAIL undef_data got %h exp 0", rsp_data); end
    checks++; if ({rsp_n, rsp_z, rsp_c, rsp_v} !== 4'b0100) begin errors++; $display("FAIL undef_flags got %b exp 0100", {rsp_n, rsp_z, rsp_c, rsp_v}); end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    run_op(4'b1000, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 1'b0, lat);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 4'b0001; req_a = '0; req_b = 64'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rsp_data !== 64'hEDCB_A987_9ABC_DEF0 || {rsp_n, rsp_z, rsp_c, rsp_v} !== 4'b1000) begin
        errors++; $display("FAIL hold_result cycle %0d got %h/%b exp edcba9879abcdef0/1000", i, rsp_data, {rsp_n, rsp_z, rsp_c, rsp_v});
      end
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
        errors++; $display("FAIL hold_handshake cycle %0d got ready=%b valid=%b exp 0/1", i, req_ready, rsp_valid);
      end
    end
    release_rsp();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL release_idle got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
    run_op(4'b1001, 64'h0, 64'h1, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency got %0d exp 3", lat); end
    checks++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL b2b_mvn_data got %h exp fffffffffffffffe", rsp_data); end
    checks++; if ({rsp_n, rsp_z, rsp_c, rsp_v} !== 4'b1000) begin errors++; $display("FAIL b2b_mvn_flags got %b exp 1000", {rsp_n, rsp_z, rsp_c, rsp_v}); end
    release_rsp();
  endtask

  task automatic test_reset_midop();
    logic seen_valid;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 4'b0010; req_a = 64'h0000_0002_0000_0001; req_b = 64'h0000_0003_0000_0001; req_cin = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if (alu_cmd !== 4'b0011) begin errors++; $display("FAIL midop_in_hi got cmd %b exp 0011", alu_cmd); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_n, rsp_z, rsp_c, rsp_v, alu_in1, alu_in2, alu_cmd, alu_cin} !== '0) begin
      errors++; $display("FAIL midop_reset_outputs got ready=%b valid=%b data=%h alu=%h/%h/%b/%b exp all 0",
                         req_ready, rsp_valid, rsp_data, alu_in1, alu_in2, alu_cmd, alu_cin);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midop_release_ready got %b exp 1", req_ready); end
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL midop_dropped got rsp_valid seen=%b exp 0", seen_valid); end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_add_overflow();
    test_and_latency();
    test_carry_in();
    test_undefined();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_wide_seq.md
# alu_wide_seq

Sequencer that performs 64-bit (two-word) arithmetic and logic operations by driving the 32-bit combinational ALU twice: low word first, then high word with the carry chained. It sits between the execute stage (or a multi-cycle instruction unit) and the ALU port. It accepts one request at a time through a valid/ready handshake and returns the 64-bit result with NZCV flags through a second valid/ready handshake.

## Interface
- WORD_W, 32, ALU word width; operands and result are 2*WORD_W.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_cmd  in  4  ALU command code: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
- req_a, req_b  in  2*WORD_W  operands.
- req_cin  in  1  carry input for ADC/SBC low word.
- rsp_valid  out  1  result held.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  2*WORD_W  result.
- rsp_n, rsp_z, rsp_c, rsp_v  out  1 each  flags of the 64-bit result.
- alu_in1, alu_in2  out  WORD_W  ALU operands.
- alu_cin  out  1  ALU carry in.
- alu_cmd  out  4  ALU command.
- alu_out  in  WORD_W; alu_cout, alu_v, alu_z  in  1  ALU results (combinational, same cycle).

## Operation
- FSM states: IDLE, LO, HI, DONE. The reset state is IDLE.
- IDLE: req_ready=1. A request is accepted when req_valid&req_ready. The command, operands and cin are latched, and the FSM moves to LO.
- LO: drive the low words. The low command equals the request command. alu_cin=req_cin. At the edge, capture alu_out into res_lo, alu_cout into c_lo, and alu_z into z_lo. Move to HI.
- HI: drive the high words. Command mapping: ADD/ADC→ADC with alu_cin=c_lo. SUB/SBC→SBC with alu_cin=~c_lo (ALU carry on subtract is a borrow). All other commands pass through unchanged with alu_cin=0. At the edge, capture the high result, cout and V. Move to DONE.
- DONE: rsp_valid=1. Return to IDLE on rsp_ready.
- Flags: N=res_hi[31]. Z=z_lo&z_hi. C=alu_cout from the final word, raw ALU convention (borrow for SUB/SBC). V=alu_v from the final word.
- MOV, MVN and logical commands give C=0 and V=0.
- An undefined req_cmd is accepted and gives a zero result with Z=1 and C=V=N=0.
- Outside LO and HI, alu_cmd=0000 and alu_in1, alu_in2 and alu_cin are 0.

## Timing
- Reset values: req_ready=0 while rst is high, then 1 in IDLE. rsp_valid=0. rsp_data=0. All flags=0. All alu_* outputs=0.
- Latency: rsp_valid rises 3 cycles after the accept edge (accept→LO→HI→DONE).
- Throughput: one request per 4 cycles at best.
- rsp_data and the flags are stable while rsp_valid=1 && !rsp_ready.
- No new request is accepted in DONE; req_ready=0 there.
- Changes on req_* after acceptance have no effect.
- rst asserted in any state returns the block to IDLE immediately. The in-flight operation is dropped and not replayed.

## Configuration
- ALU_SEQ_SINGLE_EN: when defined, adds input req_single (1 bit, latched at accept).
- With req_single=1, the FSM goes LO→DONE.
- In that case rsp_data={WORD_W zeros, res_lo}, and the flags come from the low word: N=res_lo[31], Z=z_lo, C=cout_lo, V=alu_v in LO. Latency is 2 cycles.
- When the macro is undefined, the port is absent and every request takes two words.

## Structure
- Shared package alu_pkg:
  - 4-bit command constants (CMD_MOV … CMD_EOR).
  - FSM state enum.
  - Function hi_cmd(cmd) returning the high-word command.
- One natural sub-module: wide_cmd_map. It is combinational and maps (state, latched cmd, c_lo, req_cin) to alu_cmd/alu_cin.
- The FSM, operand muxing and result registers stay in alu_wide_seq.

## Test plan
- ADD 0x0000_0000_FFFF_FFFF + 0x1 → rsp_data=0x0000_0001_0000_0000; N=0 Z=0 C=0 V=0. In HI, alu_cmd=0011 and alu_cin=1.
- SUB 0x0000_0001_0000_0000 − 0x1 → 0x0000_0000_FFFF_FFFF; C=0 V=0. In HI, alu_cmd=0101 and alu_cin=0.
- ADD 0x7FFF_FFFF_FFFF_FFFF + 0x1 → 0x8000_0000_0000_0000; N=1 V=1 C=0 Z=0.
- AND 0xF0F0_F0F0_F0F0_F0F0 & 0x0F0F_0F0F_0F0F_0F0F → 0; Z=1 and the other flags 0. rsp_valid 3 cycles after accept.
- Hold rsp_ready=0 for 5 cycles in DONE → rsp_data and flags unchanged, req_ready=0. rsp_ready=1 → IDLE next cycle, and the next request is accepted.
- Assert rst during HI → all outputs zero at once. After release, req_ready=1 and no rsp_valid ever appears for the dropped request.
